// File: rtl/tube_bin2bcd_pkg.sv
// Shared types and constants for the tube_bin2bcd binary-to-BCD converter.
package tube_bin2bcd_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Internal accumulator depth in BCD digits; ten digits cover 2^32-1.
  localparam int INT_DIGITS = 10;

  // Bit counter width; must hold the value 32.
  localparam int CNT_W = 6;

  // Value shown on the tube when the result does not fit in eight digits.
  localparam logic [31:0] BCD_SAT = 32'h9999_9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the next left shift, so that the shift carries into the next digit.
module bcd_digit_adj
  import tube_bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  // Add 3 to digits 5..9; the largest result, 9 + 3 = 12, still fits in 4 bits.
  always_comb begin
    digit_adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;
  end

endmodule

// File: rtl/tube_bin2bcd.sv
// Sequential 32-bit binary to 8-digit packed BCD converter for the tube driver.
// Uses shift-and-add-3 and processes one bit per clock. The result saturates
// to 99999999 with ovf=1 when it needs more than eight digits.
// Optional feature: define TUBE_BIN2BCD_SIGNED_EN to treat bin_in as two's
// complement. The magnitude is then converted and its sign is reported on neg.
module tube_bin2bcd
  import tube_bin2bcd_pkg::*;
#(
  parameter int BIN_W      = 32,
  parameter int OUT_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic                    neg
);

  localparam int ACC_W = 4 * INT_DIGITS;
  localparam int OUT_W = 4 * OUT_DIGITS;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic [BIN_W-1:0]   bin_sr;
  logic [BIN_W-1:0]   load_val;
  logic [CNT_W-1:0]   cnt;

`ifdef TUBE_BIN2BCD_SIGNED_EN
  logic               neg_cap;   // sign of the request in flight
  logic               neg_q;     // sign of the presented result
`endif

  // Per-digit correction of the whole accumulator ahead of each shift.
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit     (acc[4*g +: 4]),
      .digit_adj (acc_adj[4*g +: 4])
    );
  end

  // The corrected accumulator shifts left, and the binary MSB enters bit 0.
  assign acc_shift = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};

  // Value loaded into the shift register on accept: raw, or magnitude when signed.
  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    load_val = bin_in;
`ifdef TUBE_BIN2BCD_SIGNED_EN
    if (bin_in[BIN_W-1]) begin
      load_val = ~bin_in + BIN_W'(1);
    end
`endif
  end

  // Converter FSM with the shift/accumulate datapath and registered outputs.
  // NOTE: all state here uses non-blocking '<=' so every flop samples the
  // pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      acc     <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
`ifdef TUBE_BIN2BCD_SIGNED_EN
      neg_cap <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            bin_sr  <= load_val;
            acc     <= '0;
            cnt     <= '0;
`ifdef TUBE_BIN2BCD_SIGNED_EN
            neg_cap <= bin_in[BIN_W-1];
`endif
          end
        end

        S_SHIFT: begin
          if (cnt == CNT_W'(BIN_W)) begin
            // All bits have been shifted in, so publish the result in one step.
            state <= S_DONE;
            done  <= 1'b1;
            if (acc[ACC_W-1:OUT_W] == '0) begin
              bcd_out <= acc[OUT_W-1:0];
              ovf     <= 1'b0;
            end else begin
              bcd_out <= BCD_SAT;
              ovf     <= 1'b1;
            end
`ifdef TUBE_BIN2BCD_SIGNED_EN
            neg_q <= neg_cap;
`endif
          end else begin
            acc    <= acc_shift;
            bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
            cnt    <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TUBE_BIN2BCD_SIGNED_EN
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_tube_bin2bcd.sv
// Self-checking bench for tube_bin2bcd. Expected results are pushed to a
// scoreboard queue when a request is driven, and popped when done pulses.
// Handshake timing is checked inline by the scenario tasks.
module tb_tube_bin2bcd;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        ovf;
  logic        neg;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tube_bin2bcd #(
    .BIN_W      (32),
    .OUT_DIGITS (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .neg     (neg)
  );

  // Reference model: decimal digits by repeated division, saturating above 8 digits.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    logic [31:0] mag;
    longint      m;
    e.neg = 1'b0;
    mag   = v;
`ifdef TUBE_BIN2BCD_SIGNED_EN
    if (v[31]) begin
      e.neg = 1'b1;
      mag   = 32'd0 - v;
    end
`endif
    m     = longint'({32'd0, mag});
    e.bcd = 32'd0;
    e.ovf = 1'b0;
    if (m > 64'd99999999) begin
      e.bcd = 32'h9999_9999;
      e.ovf = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        e.bcd[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 bcd=%h, required no pending result", bcd_out);
      end else begin
        mon_e = sb.pop_front();
        if ({bcd_out, ovf, neg} !== mon_e) begin
          miscompares++;
          $display("FAIL result: got bcd=%h ovf=%b neg=%b, required bcd=%h ovf=%b neg=%b",
                   bcd_out, ovf, neg, mon_e.bcd, mon_e.ovf, mon_e.neg);
        end
      end
    end
  end

  // Watchdog so that a stuck run still terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for done at negedges, starting with the next one; cycles counts negedges.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < budget);
  endtask

  // One start pulse, then check latency, busy length, held outputs, and return to idle.
  task automatic convert(input logic [31:0] v, input string name);
    int          k;
    int          busy_cnt;
    bit          held;
    logic [31:0] prev;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    sb.push_back(model(v));
    prev   = bcd_out;
    @(negedge clk);                 // after accepting edge 0
    start  = 1'b0;
    bin_in = $urandom;              // don't-care after accept
    k        = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_out !== prev) held = 1'b0;
      @(negedge clk);
      k++;
    end
    if (busy === 1'b1) busy_cnt++;
    vectors++;
    if (k != 33) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, required 33", name, k);
    end
    vectors++;
    if (busy_cnt != 34) begin
      miscompares++;
      $display("FAIL %s_busy_len: got %0d cycles, required 34", name, busy_cnt);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s_held: bcd_out changed during conversion, required stable %h", name, prev);
    end
    @(negedge clk);                 // after edge 34
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_idle: got busy=%b done=%b, required 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, bcd_out, ovf, neg} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b neg=%b, required all 0",
               busy, done, bcd_out, ovf, neg);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, bcd_out, ovf, neg} !== 36'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b bcd=%h ovf=%b neg=%b, required all 0",
               busy, done, bcd_out, ovf, neg);
    end
  endtask

  task automatic test_zero;
    convert(32'd0, "zero");
  endtask

  task automatic test_values;
    convert(32'd12345678,   "v12345678");
    convert(32'd99999999,   "v99999999");
    convert(32'd100000000,  "v100000000");
    convert(32'hFFFF_FFFF,  "vmax");
    convert(32'd9,          "v9");
    convert(32'd10,         "v10");
    for (int i = 0; i < 4; i++) begin
      convert($urandom_range(0, 99999999), "vrand");
    end
  endtask

  task automatic test_back_to_back;
    int t;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd7;
    sb.push_back(model(32'd7));
    sb.push_back(model(32'd7));
    wait_done(100, t);
    vectors++;
    if (done !== 1'b1 || t != 34) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b after %0d, required done=1 after 34", done, t);
    end
    repeat (10) @(negedge clk);
    bin_in = 32'd9;                 // mid-conversion change must not affect result
    wait_done(100, t);
    vectors++;
    if (done !== 1'b1 || (10 + t) != 35) begin
      miscompares++;
      $display("FAIL b2b_period: got done=%b spacing %0d, required done=1 spacing 35", done, 10 + t);
    end
    sb.push_back(model(32'd9));
    @(negedge clk);                 // idle; start still high
    @(negedge clk);                 // accepted with bin_in=9
    start = 1'b0;
    wait_done(100, t);
    vectors++;
    if (done !== 1'b1 || t != 33) begin
      miscompares++;
      $display("FAIL b2b_third: got done=%b after %0d, required done=1 after 33", done, t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int done_seen;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd42;
    sb.push_back(model(32'd42));
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bcd_out, ovf, neg} !== 36'd0) begin
      miscompares++;
      $display("FAIL abort_clear: got busy=%b done=%b bcd=%h ovf=%b neg=%b, required all 0",
               busy, done, bcd_out, ovf, neg);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", done_seen);
    end
    convert(32'd42, "after_abort");
  endtask

`ifdef TUBE_BIN2BCD_SIGNED_EN
  task automatic test_signed;
    convert(32'hFFFF_FFFF, "minus1");
    convert(32'h8000_0000, "minmag");
    convert(32'd0,         "szero");
    convert(32'd0 - 32'd12345678, "minus12345678");
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_reset_abort();
`ifdef TUBE_BIN2BCD_SIGNED_EN
    test_signed();
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
